// File: rtl/barrel_req_sched.sv
// barrel_req_sched: round-robin scheduler that time-shares one 8-bit barrel
// shifter between two requesters. Amounts wider than the shifter's 3-bit range
// are split into passes of at most 7, one pass per cycle. Results return on a
// single valid/ready port tagged with the issuing requester.

// Combinational logical left shift, zero fill, built as three binary stages.
module barrel_shifter (
   input  logic [7:0] din,
   input  logic [2:0] amt,
   output logic [7:0] dout
);

   logic [7:0] stage1;
   logic [7:0] stage2;

   assign stage1 = amt[0] ? {din[6:0],    1'b0}  : din;
   assign stage2 = amt[1] ? {stage1[5:0], 2'b00} : stage1;
   assign dout   = amt[2] ? {stage2[3:0], 4'h0}  : stage2;

endmodule

module barrel_req_sched #(
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [7:0]       req_data0,
   input  logic [AMT_W-1:0] req_amt0,
   input  logic [7:0]       req_data1,
   input  logic [AMT_W-1:0] req_amt1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_id,
   output logic             busy,
   output logic [7:0]       done_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest amount a single pass through the shifter can apply.
   localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(7);

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [7:0]       opnd_q, opnd_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic [7:0]       done_cnt_q, done_cnt_d;

   logic             gnt_vld;
   logic             gnt_id;
   logic [7:0]       gnt_data;
   logic [AMT_W-1:0] gnt_amt;
   logic [2:0]       step;
   logic [AMT_W-1:0] rem_nxt;
   logic [7:0]       sh_out;

   // Round-robin grant: the priority requester wins if valid, otherwise the other one.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (state_q == IDLE) begin
         if (req_valid[prio_q]) begin
            gnt_vld = 1'b1;
            gnt_id  = prio_q;
         end else if (req_valid[~prio_q]) begin
            gnt_vld = 1'b1;
            gnt_id  = ~prio_q;
         end
      end
   end

   assign gnt_data = gnt_id ? req_data1 : req_data0;
   assign gnt_amt  = gnt_id ? req_amt1  : req_amt0;

   // No command may be accepted while reset is asserted, even though the state reads IDLE.
   assign req_ready = (rst_n && gnt_vld) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

   // Pass size: saturate at 7; the shifter sees a zero amount outside SHIFT.
   always_comb begin
      step = 3'd0;
      if (state_q == SHIFT) begin
         step = (rem_q > STEP_MAX) ? 3'd7 : rem_q[2:0];
      end
   end

   assign rem_nxt = rem_q - AMT_W'(step);

   barrel_shifter u_shifter (
      .din  (opnd_q),
      .amt  (step),
      .dout (sh_out)
   );

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      opnd_d      = opnd_q;
      rem_d       = rem_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      done_cnt_d  = done_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               opnd_d   = gnt_data;
               rem_d    = gnt_amt;
               rsp_id_d = gnt_id;
               prio_d   = ~gnt_id;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            opnd_d = sh_out;
            rem_d  = rem_nxt;
            // An amount of 0 lands here on its first pass with step 0.
            if (rem_nxt == '0) begin
               rsp_data_d  = sh_out;
               rsp_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset aborts any command in flight without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         opnd_q      <= 8'h00;
         rem_q       <= '0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         done_cnt_q  <= 8'h00;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q     <= state_d;
         prio_q      <= prio_d;
         opnd_q      <= opnd_d;
         rem_q       <= rem_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_barrel_req_sched.sv
// Directed testbench for barrel_req_sched with hand-computed expected values.
module tb_barrel_req_sched;

   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [7:0]       req_data0;
   logic [AMT_W-1:0] req_amt0;
   logic [7:0]       req_data1;
   logic [AMT_W-1:0] req_amt1;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;
   logic             rsp_id;
   logic             busy;
   logic [7:0]       done_cnt;

   int               vec_cnt = 0;
   int               err_cnt = 0;
   logic [7:0]       exp_cnt;

   barrel_req_sched #(.AMT_W(AMT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data0 (req_data0),
      .req_amt0  (req_amt0),
      .req_data1 (req_data1),
      .req_amt1  (req_amt1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   // Hard stop if the sequence ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full transaction from one requester: accept, wait for the result, consume it.
   task automatic do_txn(input logic id, input logic [7:0] d, input logic [AMT_W-1:0] a,
                         input logic [7:0] exp_d, input int exp_lat, input string tag);
      int cyc;
      if (id) begin
         req_data1 = d; req_amt1 = a; req_valid = 2'b10;
      end else begin
         req_data0 = d; req_amt0 = a; req_valid = 2'b01;
      end
      #1;
      check({tag, ".ready"}, 32'(req_ready), id ? 32'h2 : 32'h1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      check({tag, ".busy"}, 32'(busy), 32'h1);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!rsp_valid && cyc < 8);
      check({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
      check({tag, ".data"}, 32'(rsp_data), 32'(exp_d));
      check({tag, ".id"}, 32'(rsp_id), 32'(id));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check({tag, ".vld_clr"}, 32'(rsp_valid), 32'h0);
      check({tag, ".idle"}, 32'(busy), 32'h0);
      check({tag, ".cnt"}, 32'(done_cnt), 32'(exp_cnt));
   endtask

   initial begin
      int n;
      rst_n     = 1'b1;
      req_valid = 2'b00;
      req_data0 = 8'h00; req_amt0 = '0;
      req_data1 = 8'h00; req_amt1 = '0;
      rsp_ready = 1'b0;
      exp_cnt   = 8'h00;
      #2 rst_n = 1'b0;
      repeat (2) tick();
      check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst.rsp_data",  32'(rsp_data),  32'h0);
      check("rst.rsp_id",    32'(rsp_id),    32'h0);
      check("rst.busy",      32'(busy),      32'h0);
      check("rst.done_cnt",  32'(done_cnt),  32'h0);
      check("rst.req_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: single request, short shift
      do_txn(1'b0, 8'hA5, 4'd3, 8'h28, 1, "t1");

      // 2: multi-pass shifts and the single-pass maximum
      do_txn(1'b1, 8'h01, 4'd9, 8'h00, 2, "t2a");
      do_txn(1'b1, 8'h01, 4'd7, 8'h80, 1, "t2b");
      do_txn(1'b1, 8'hFF, 4'd8, 8'h00, 2, "t2c");

      // 3: contention straight after reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_cnt = 8'h00;
      tick();
      req_data0 = 8'hFF; req_amt0 = 4'd1;
      req_data1 = 8'h0F; req_amt1 = 4'd4;
      req_valid = 2'b11;
      #1;
      check("t3.gnt0", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 2'b10;
      check("t3.shift_ready", 32'(req_ready), 32'h0);
      tick();
      check("t3.r0_vld",  32'(rsp_valid), 32'h1);
      check("t3.r0_data", 32'(rsp_data),  32'hFE);
      check("t3.r0_id",   32'(rsp_id),    32'h0);
      check("t3.done_ready", 32'(req_ready), 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("t3.gnt1", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      tick();
      check("t3.r1_vld",  32'(rsp_valid), 32'h1);
      check("t3.r1_data", 32'(rsp_data),  32'hF0);
      check("t3.r1_id",   32'(rsp_id),    32'h1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("t3.cnt", 32'(done_cnt), 32'(exp_cnt));
      req_valid = 2'b11;
      #1;
      check("t3.prio0", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      tick();

      // 4: backpressure in DONE
      req_data0 = 8'h33; req_amt0 = 4'd2;
      req_data1 = 8'h0F; req_amt1 = 4'd0;
      req_valid = 2'b01;
      #1;
      check("t4.ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 2'b10;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t4.hold_vld",   32'(rsp_valid), 32'h1);
         check("t4.hold_data",  32'(rsp_data),  32'hCC);
         check("t4.hold_id",    32'(rsp_id),    32'h0);
         check("t4.hold_ready", 32'(req_ready), 32'h0);
         check("t4.hold_cnt",   32'(done_cnt),  32'(exp_cnt));
         check("t4.hold_busy",  32'(busy),      32'h1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      check("t4.cnt",   32'(done_cnt),  32'(exp_cnt));
      check("t4.idle",  32'(busy),      32'h0);
      check("t4.gnt1",  32'(req_ready), 32'h2);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      tick();
      check("t4.r1_data", 32'(rsp_data), 32'h0F);
      check("t4.r1_id",   32'(rsp_id),   32'h1);
      rsp_ready = 1'b1;
      tick();
      exp_cnt++;
      repeat (3) tick();
      rsp_ready = 1'b0;
      check("t4.idle_rdy_cnt", 32'(done_cnt),  32'(exp_cnt));
      check("t4.idle_rdy_vld", 32'(rsp_valid), 32'h0);

      // 5: zero amount, then wrap the completion counter
      do_txn(1'b0, 8'h5A, 4'd0, 8'h5A, 1, "t5a");
      n = 256 - int'(exp_cnt);
      for (int i = 0; i < n - 1; i++) begin
         do_txn(1'b0, 8'h01, 4'd1, 8'h02, 1, "t5w");
      end
      check("t5.cnt_ff", 32'(done_cnt), 32'hFF);
      do_txn(1'b0, 8'h01, 4'd1, 8'h02, 1, "t5last");
      check("t5.cnt_wrap", 32'(done_cnt), 32'h00);

      // 6: reset during a multi-pass shift
      req_data0 = 8'hFF; req_amt0 = 4'd15;
      req_valid = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      tick();
      check("t6.mid_busy", 32'(busy),      32'h1);
      check("t6.mid_vld",  32'(rsp_valid), 32'h0);
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      check("t6.rst_vld",   32'(rsp_valid), 32'h0);
      check("t6.rst_data",  32'(rsp_data),  32'h0);
      check("t6.rst_id",    32'(rsp_id),    32'h0);
      check("t6.rst_busy",  32'(busy),      32'h0);
      check("t6.rst_cnt",   32'(done_cnt),  32'h0);
      check("t6.rst_ready", 32'(req_ready), 32'h0);
      exp_cnt = 8'h00;
      repeat (2) tick();
      req_valid = 2'b00;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6.post_vld",  32'(rsp_valid), 32'h0);
         check("t6.post_busy", 32'(busy),      32'h0);
      end
      req_data1 = 8'h11; req_amt1 = 4'd1;
      req_valid = 2'b11;
      #1;
      check("t6.prio_rst", 32'(req_ready), 32'h1);
      do_txn(1'b0, 8'h81, 4'd15, 8'h00, 3, "t6b");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
